// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, the nop word and the
// memory-stage state encoding used by the M stage and its helpers.
package pipeline_pkg;

    localparam logic [4:0]  OPC_SW = 5'b00111;
    localparam logic [4:0]  OPC_LW = 5'b01000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    function automatic logic is_mem_op(input logic [31:0] instr);
        return (instr[31:27] == OPC_SW) || (instr[31:27] == OPC_LW);
    endfunction

    function automatic logic is_store(input logic [31:0] instr);
        return instr[31:27] == OPC_SW;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// 8-bit cycle counter bounding how long a data-memory request may wait
// for its acknowledge; terminal flags the last permitted REQ cycle.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] count,
    output logic       terminal
);

    logic [7:0] count_d;
    logic [7:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access_stage.sv
// M stage: runs lw/sw against a multi-cycle data memory over req/ack,
// stalling upstream and bubbling downstream until the access resolves.
module memory_access_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       store_data,
    input  logic [31:0]       instruction_in,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       alu_out,
    output logic [31:0]       dmem_out,
    output logic [31:0]       instruction_out,
    output logic              stall,
    output logic              mem_err
);

    mem_state_e        state_d,     state_q;
    logic              mem_req_d,   mem_req_q;
    logic              mem_we_d,    mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
    logic [31:0]       mem_wdata_d, mem_wdata_q;
    logic [31:0]       captured_d,  captured_q;
    logic              mem_err_d,   mem_err_q;

    logic       mem_op;
    logic       cnt_clear;
    logic       cnt_enable;
    logic [7:0] cnt_value;
    logic       cnt_terminal;

    assign mem_op = is_mem_op(instruction_in);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (cnt_value),
        .terminal (cnt_terminal)
    );

    // Counter restarts for every new access and only advances while waiting.
    assign cnt_clear  = (state_q == IDLE);
    assign cnt_enable = (state_q == REQ) && !mem_ack && !cnt_terminal;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        captured_d  = captured_q;
        mem_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store(instruction_in);
                    mem_addr_d  = alu_in[ADDR_W-1:0];
                    mem_wdata_d = store_data;
                end
            end
            REQ: begin
                // An ack arriving in the final allowed cycle still wins.
                if (mem_ack) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    captured_d = mem_we_q ? 32'h0 : mem_rdata;
                end else if (cnt_terminal) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    captured_d = 32'h0;
                    mem_err_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            captured_q  <= 32'h0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            captured_q  <= captured_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Downstream view: pass-through, bubble, or completed access.
    always_comb begin
        alu_out         = 32'h0;
        dmem_out        = 32'h0;
        instruction_out = NOP;
        stall           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall = 1'b1;
                end else begin
                    alu_out         = alu_in;
                    instruction_out = instruction_in;
                end
            end
            REQ: begin
                stall = 1'b1;
            end
            DONE: begin
                alu_out         = alu_in;
                dmem_out        = captured_q;
                instruction_out = instruction_in;
            end
            default: begin
                stall = 1'b1;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_err   = mem_err_q;

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory (M) stage of the 5-stage pipeline; sits directly upstream of the M/W latch.
- Takes the X/M latch outputs (ALU result, store data, instruction) and runs lw/sw against a multi-cycle data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding and emits a nop bubble downstream.
- On completion, presents alu_out, dmem_out and instruction to the M/W latch.

Parameters:
- ADDR_W, 12, data-memory word address width; mem_addr = alu_in[ADDR_W-1:0] (upper bits dropped).
- TIMEOUT, 255, maximum REQ cycles without mem_ack before abort; 1..255, counter is 8 bits.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- alu_in  in  32  ALU result from X/M latch; address for lw/sw.
- store_data  in  32  rd value for sw from X/M latch.
- instruction_in  in  32  instruction from X/M latch; opcode is [31:27].
- mem_ack  in  1  memory completion strobe, one cycle.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_req  out  1  registered access request.
- mem_we  out  1  registered write enable (1 = sw).
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  32  registered write data.
- alu_out  out  32  to M/W latch.
- dmem_out  out  32  to M/W latch; load data or 0.
- instruction_out  out  32  to M/W latch; 0 means bubble.
- stall  out  1  freeze PC, F/D, D/X and X/M latches.
- mem_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, captured data=0, timeout count=0, mem_err=0. Combinational outputs follow IDLE rules.
- A memory op is opcode 00111 (sw) or 01000 (lw). Every other opcode, including all-zero nop, is pass-through.
- IDLE, non-mem op:
  - alu_out=alu_in, dmem_out=0, instruction_out=instruction_in, stall=0, combinational (0-cycle latency).
- IDLE, mem op:
  - stall=1, instruction_out=0, alu_out=0, dmem_out=0.
  - Next edge: state→REQ; mem_req←1, mem_we←(sw), mem_addr←alu_in[ADDR_W-1:0], mem_wdata←store_data, count←0.
- REQ:
  - stall=1, bubble outputs; mem_req, addr and wdata are held stable.
  - mem_ack=1: capture mem_rdata if lw (0 if sw); mem_req←0; state→DONE.
  - Else if count==TIMEOUT-1: mem_req←0; captured←32'h0; mem_err←1 for the next cycle; state→DONE.
  - Else count←count+1.
- DONE:
  - stall=0, alu_out=alu_in, dmem_out=captured, instruction_out=instruction_in.
  - Next edge: state→IDLE, so upstream advances on this edge.
- Upstream holds its inputs stable while stall=1. This block relies on that and does not re-latch the instruction.
- Cycle budget, ack in the k-th REQ cycle (k≥1): stall high for 1+k cycles; the instruction is emitted in the following cycle.
- mem_ack outside REQ is ignored. mem_ack in the timeout cycle wins: data is captured and mem_err stays 0.
- Back-to-back mem ops: DONE→IDLE, then the second op starts in IDLE. No overlap; at most one outstanding request.
- Reset mid-REQ: mem_req drops immediately; the pending access is abandoned; no mem_err.

Decomposition:
- Shared package pipeline_pkg: opcode constants OPC_SW=5'b00111, OPC_LW=5'b01000, NOP=32'h0, and the 2-bit state encoding IDLE=0, REQ=1, DONE=2.
- One natural sub-module: mem_timeout_counter (8-bit, clear/enable/terminal-count output, async active-low reset).

Test Plan:
- Reset asserted mid-REQ (mem_req=1) → mem_req=0 asynchronously; after release, state IDLE, stall=0, mem_err never pulses.
- add (opcode 00000), alu_in=0x00000005 → same cycle: alu_out=5, dmem_out=0, instruction_out=instruction_in, stall=0, mem_req never rises.
- lw, alu_in=0x00000010, mem_ack in the 2nd REQ cycle with rdata=0xCAFEF00D:
  - stall=1 for 3 cycles; mem_addr=0x010, mem_we=0.
  - Next cycle: dmem_out=0xCAFEF00D with the lw instruction.
- sw, alu_in=0x00001ABC, store_data=0x12345678, immediate ack → mem_addr=0xABC (truncated), mem_we=1, mem_wdata=0x12345678; stall 2 cycles; dmem_out=0.
- lw with TIMEOUT=4, no ack → mem_req high for exactly 4 cycles; mem_err pulses 1 cycle; dmem_out=0; pipeline resumes.
- Two consecutive lw (acks after 1 and 3 cycles), with a stray mem_ack in IDLE → two bubbles sequences of 2 and 4 stall cycles; the stray ack is ignored; correct data for each.
